mem_lsu: RTL
============

# mem_lsu

Memory-access stage of the yadan pipeline, placed between the EX/MEM register and the MEM/WB register. It passes ALU write-back results through unchanged. For loads and stores it runs a data-bus transaction with a request/grant/response handshake, aligns and sign-extends load data, and holds `stallreq` until the access completes. It then presents `mem_wd`, `mem_wreg` and `mem_wdata` to the MEM/WB register.

## Interface
- No parameters; widths come from `yadan_defs.v` (`RegBus` = 32, `RegAddrBus` = 5).
- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous, active-high reset
- `ex_wd`  in  5  destination register from EX/MEM
- `ex_wreg`  in  1  register write enable from EX/MEM
- `ex_wdata`  in  32  ALU result from EX/MEM
- `ex_memop`  in  4  memory op: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8
- `ex_memaddr`  in  32  effective address
- `ex_storedata`  in  32  rs2 value for stores
- `hold`  in  1  stall-controller stop for this stage (`stalled[4]`)
- `flush`  in  1  kill the current instruction
- `dbus_req`, `dbus_we`  out  1  bus request / write
- `dbus_addr`  out  32  word-aligned address
- `dbus_be`  out  4  byte enables
- `dbus_wdata`  out  32  lane-replicated store data
- `dbus_gnt`  in  1  request accepted this cycle
- `dbus_rvalid`  in  1  read data valid
- `dbus_rdata`  in  32  read data
- `mem_wd`  out  5  to MEM/WB
- `mem_wreg`  out  1  to MEM/WB
- `mem_wdata`  out  32  to MEM/WB
- `stallreq`  out  1  stall request to the stall controller
- `mem_excp_misalign`  out  1  misaligned-access flag
- `mem_excp_addr`  out  32  faulting address

## Operation
- FSM states: IDLE, WAIT (load issued, awaiting `rvalid`), DONE (result held in a register), DRAIN (flushed load, discard the response).
- IDLE with NONE: outputs pass `ex_*` through combinationally; `stallreq` = 0.
- IDLE with a load or store, no flush:
  - `dbus_req` = 1 and `stallreq` = 1.
  - On `gnt`, a load goes to WAIT and a store goes to DONE.
  - Without `gnt`, the FSM stays in IDLE and the request is held stable.
- WAIT:
  - `stallreq` = 1.
  - On `rvalid`, the aligned data is captured into `ld_q` and the FSM goes to DONE.
  - `flush` moves it to DRAIN.
- DONE:
  - `stallreq` = 0. Outputs come from registered copies: `wd_q`/`wreg_q`/`ld_q`.
  - A store outputs `mem_wreg` = 0.
  - Returns to IDLE unless `hold` = 1, in which case it stays in DONE. There is never a re-issue.
- DRAIN: `stallreq` = 0 and `mem_wreg` = 0. On `rvalid` the data is dropped and the FSM returns to IDLE.
- Byte enables and data:
  - Byte: `be` = 0001 << addr[1:0].
  - Half: `be` = 0011 << addr[1:0].
  - Word: `be` = 1111.
  - Store data is replicated across lanes.
- Load alignment: shift `rdata` right by 8·addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Flush in IDLE suppresses `dbus_req` and forces `mem_wreg` = 0. Flush in DONE forces `mem_wreg` = 0 and the FSM goes to IDLE.
- A `gnt` and a `flush` in the same IDLE cycle: the access counts as issued, so a load goes to DRAIN and a store is already committed.

## Timing
- Reset (`rst` = 1 at a posedge):
  - State returns to IDLE; `wd_q`, `wreg_q`, `ld_q` are cleared to 0.
  - While `rst` is high, all outputs are forced to 0.
  - Reset in the middle of WAIT abandons the access; the bus owner must also be reset.
- Zero-wait bus (`gnt` in the request cycle, `rvalid` one cycle later):
  - Load: 3 cycles (IDLE, WAIT, DONE), with `stallreq` high for 2.
  - Store: 2 cycles, with `stallreq` high for 1.
  - Each extra cycle of `gnt` or `rvalid` latency adds one cycle.
- A non-memory op has 0 added latency.
- `dbus_*` outputs are combinational from state and the `ex_*` inputs. At most one outstanding request.

## Configuration
- `MEM_LSU_MISALIGN_EN` defined:
  - Misaligned accesses are halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Such an access issues no bus request. `mem_excp_misalign` = 1 and `mem_excp_addr` = address, for the cycle the op sits in IDLE.
  - `mem_wreg` = 0 and `stallreq` = 0.
- Undefined: alignment is not checked, `mem_excp_misalign` is tied to 0 and `mem_excp_addr` to 0, and address bits below the access size are ignored when forming `be`.

## Structure
- `yadan_defs.v` holds:
  - the memop encodings (`MemOpNone` … `MemOpSW`),
  - the FSM state encodings,
  - `RegBus` and `RegAddrBus`.
- The natural sub-module is `mem_lsu_align`: a combinational block that computes `be`, store-lane replication, and load shift/extend.

## Test plan
- ALU op: `ex_wd` = 5, `ex_wdata` = 0x1234, `ex_memop` = NONE -> same cycle `mem_wd` = 5, `mem_wreg` = 1, `mem_wdata` = 0x1234, `stallreq` = 0.
- LB at addr 0x103 with `rdata` = 0x80FF_0000 and a zero-wait bus -> `dbus_be` = 1000; DONE in cycle 3 with `mem_wdata` = 0xFFFF_FF80. LBU on the same access returns 0x0000_0080.
- SH at 0x202 with data 0xABCD, `gnt` delayed 2 cycles -> `req` held for 3 cycles, `be` = 1100, `wdata` = 0xABCD_ABCD, `mem_wreg` = 0, `stallreq` high for 3 cycles.
- LW, then `flush` in WAIT, `rvalid` 2 cycles later -> DRAIN, no write-back, FSM back in IDLE after `rvalid`.
- DONE with `hold` = 1 for 3 cycles -> stays in DONE, `dbus_req` = 0 throughout, a single bus transaction total.
- With `MEM_LSU_MISALIGN_EN`: LW at 0x1001 -> `mem_excp_misalign` = 1, `mem_excp_addr` = 0x1001, `dbus_req` = 0. `rst` asserted during WAIT -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the yadan memory-access stage: bus widths, memop codes,
// LSU FSM states and the write-back record.
package mem_lsu_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int NUM_LANES  = RegBus / 8;

    typedef enum logic [3:0] {
        MemOpNone = 4'd0,
        MemOpLB   = 4'd1,
        MemOpLH   = 4'd2,
        MemOpLW   = 4'd3,
        MemOpLBU  = 4'd4,
        MemOpLHU  = 4'd5,
        MemOpSB   = 4'd6,
        MemOpSH   = 4'd7,
        MemOpSW   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StDone  = 2'd2,
        StDrain = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
        logic [RegBus-1:0]     wdata;
    } wb_t;

    // log2 of the access size in bytes; non-memory ops report word size
    function automatic logic [1:0] op_size(memop_e op);
        case (op)
            MemOpLB, MemOpLBU, MemOpSB: op_size = 2'd0;
            MemOpLH, MemOpLHU, MemOpSH: op_size = 2'd1;
            default:                    op_size = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables, store-lane replication and load
// shift/extend. Address bits below the access size are ignored.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [3:0]           memop,
    input  logic [1:0]           addr_lo,
    input  logic [RegBus-1:0]    storedata,
    input  logic [RegBus-1:0]    rdata,
    output logic                 is_load,
    output logic                 is_store,
    output logic [NUM_LANES-1:0] be,
    output logic [RegBus-1:0]    wdata,
    output logic [RegBus-1:0]    ldata
);

    memop_e            op;
    logic [1:0]        off;
    logic [2:0]        nbytes;
    logic [RegBus-1:0] shifted;

    always_comb begin
        op       = memop_e'(memop);
        is_load  = (op == MemOpLB) || (op == MemOpLH) || (op == MemOpLW) ||
                   (op == MemOpLBU) || (op == MemOpLHU);
        is_store = (op == MemOpSB) || (op == MemOpSH) || (op == MemOpSW);
        case (op_size(op))
            2'd0: begin
                off    = addr_lo;
                nbytes = 3'd1;
                wdata  = {4{storedata[7:0]}};
            end
            2'd1: begin
                off    = {addr_lo[1], 1'b0};
                nbytes = 3'd2;
                wdata  = {2{storedata[15:0]}};
            end
            default: begin
                off    = 2'd0;
                nbytes = 3'd4;
                wdata  = storedata;
            end
        endcase
        shifted = rdata >> {off, 3'b000};
        case (op)
            MemOpLB:  ldata = {{24{shifted[7]}}, shifted[7:0]};
            MemOpLBU: ldata = {24'd0, shifted[7:0]};
            MemOpLH:  ldata = {{16{shifted[15]}}, shifted[15:0]};
            MemOpLHU: ldata = {16'd0, shifted[15:0]};
            default:  ldata = shifted;
        endcase
    end

    // a lane is enabled when it falls inside [off, off+nbytes)
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign be[i] = (is_load || is_store) &&
                       ({1'b0, off} <= 3'(i)) && (3'(i) < ({1'b0, off} + nbytes));
    end

endmodule

// File: rtl/mem_lsu.sv
// yadan memory-access stage: ALU pass-through plus a single-outstanding data-bus
// LSU. Define MEM_LSU_MISALIGN_EN to trap misaligned halfword/word accesses.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [RegBus-1:0]     ex_wdata,
    input  logic [3:0]            ex_memop,
    input  logic [RegBus-1:0]     ex_memaddr,
    input  logic [RegBus-1:0]     ex_storedata,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [RegBus-1:0]     dbus_addr,
    output logic [3:0]            dbus_be,
    output logic [RegBus-1:0]     dbus_wdata,
    input  logic                  dbus_gnt,
    input  logic                  dbus_rvalid,
    input  logic [RegBus-1:0]     dbus_rdata,
    output logic [RegAddrBus-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [RegBus-1:0]     mem_wdata,
    output logic                  stallreq,
    output logic                  mem_excp_misalign,
    output logic [RegBus-1:0]     mem_excp_addr
);

    lsu_state_e            state;
    logic [RegAddrBus-1:0] wd_q;
    logic                  wreg_q;
    logic [RegBus-1:0]     ld_q;

    logic                  is_load, is_store, is_mem, misalign, issue_cand;
    logic [NUM_LANES-1:0]  be;
    logic [RegBus-1:0]     st_wdata, ld_data;
    wb_t                   wb;

    mem_lsu_align u_align (
        .memop     (ex_memop),
        .addr_lo   (ex_memaddr[1:0]),
        .storedata (ex_storedata),
        .rdata     (dbus_rdata),
        .is_load   (is_load),
        .is_store  (is_store),
        .be        (be),
        .wdata     (st_wdata),
        .ldata     (ld_data)
    );

    assign is_mem = is_load || is_store;

`ifdef MEM_LSU_MISALIGN_EN
    always_comb begin
        case (op_size(memop_e'(ex_memop)))
            2'd1:    misalign = is_mem && ex_memaddr[0];
            2'd2:    misalign = is_mem && (ex_memaddr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign issue_cand = (state == StIdle) && is_mem && !misalign;

    always_comb begin
        dbus_req          = 1'b0;
        dbus_we           = 1'b0;
        dbus_addr         = '0;
        dbus_be           = '0;
        dbus_wdata        = '0;
        wb                = '0;
        stallreq          = 1'b0;
        mem_excp_misalign = 1'b0;
        mem_excp_addr     = '0;
        if (!rst) begin
            dbus_req = issue_cand && !flush;
            if (dbus_req) begin
                dbus_we    = is_store;
                dbus_addr  = {ex_memaddr[RegBus-1:2], 2'b00};
                dbus_be    = be;
                dbus_wdata = st_wdata;
            end
            case (state)
                StIdle: begin
                    wb.wd = ex_wd;
                    if (misalign) begin
                        mem_excp_misalign = 1'b1;
                        mem_excp_addr     = ex_memaddr;
                    end else if (is_mem) begin
                        stallreq = !flush;
                    end else begin
                        wb.wreg  = ex_wreg && !flush;
                        wb.wdata = ex_wdata;
                    end
                end
                StWait: begin
                    stallreq = 1'b1;
                    wb.wd    = wd_q;
                end
                StDone: begin
                    wb.wd    = wd_q;
                    wb.wreg  = wreg_q && !flush;
                    wb.wdata = ld_q;
                end
                default: ;
            endcase
        end
    end

    assign mem_wd    = wb.wd;
    assign mem_wreg  = wb.wreg;
    assign mem_wdata = wb.wdata;

    // A grant coinciding with flush still counts as issued: loads must drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            wd_q   <= '0;
            wreg_q <= 1'b0;
            ld_q   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (issue_cand && dbus_gnt) begin
                        wd_q   <= ex_wd;
                        wreg_q <= is_load && ex_wreg;
                        ld_q   <= '0;
                        if (flush)
                            state <= is_load ? StDrain : StIdle;
                        else
                            state <= is_load ? StWait : StDone;
                    end
                end
                StWait: begin
                    if (dbus_rvalid) begin
                        ld_q  <= ld_data;
                        state <= flush ? StIdle : StDone;
                    end else if (flush) begin
                        state <= StDrain;
                    end
                end
                StDone: begin
                    if (flush || !hold)
                        state <= StIdle;
                end
                default: begin
                    if (dbus_rvalid)
                        state <= StIdle;
                end
            endcase
        end
    end

endmodule
